// File: rtl/bb_fusion_accumulator_pkg.sv
// Shared types and helpers for the bitbrick fusion datapath.
// Parameter defaults, accumulator FSM states, sign-extension.
package bitfusion_pkg;

   localparam int NUM_BB_D = 4;
   localparam int PROD_W_D = 10;
   localparam int ACC_W_D  = 24;
   localparam int CNT_W_D  = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } fsm_e;

   // Sign-extend the low w bits of v to the full 64 bits.
   function automatic logic [63:0] sext64(
      input logic [63:0] v,
      input int          w
   );
      logic [63:0] m;
      m = ~64'd0 << w;
      return v[6'(w - 1)] ? (v | m) : (v & ~m);
   endfunction

endpackage

// File: rtl/bb_fusion_if.sv
// Beat input and result output handshakes of the fusion accumulator.
// master = upstream/downstream side, slave = accumulator side.
interface bb_fusion_if
   import bitfusion_pkg::*;
#(
   parameter int NUM_BB = NUM_BB_D,
   parameter int PROD_W = PROD_W_D,
   parameter int ACC_W  = ACC_W_D,
   parameter int CNT_W  = CNT_W_D
);
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_BB*PROD_W-1:0] in_prod;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic [ACC_W-1:0]         out_acc;
   logic [CNT_W-1:0]         out_beats;
   logic                     out_ovf;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_beats, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_beats, out_ovf
   );

endinterface

// File: rtl/bb_fusion_accumulator_adder_tree.sv
// Combinational signed sum of NUM_BB packed bitbrick products.
// Each product is sign-extended to the full sum width first.
module bb_adder_tree #(
   parameter int NUM_BB = 4,
   parameter int PROD_W = 10,
   parameter int SUM_W  = PROD_W + $clog2(NUM_BB)
) (
   input  logic [NUM_BB*PROD_W-1:0] prod,
   output logic [SUM_W-1:0]         sum
);

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_BB; i++) begin
         sum = sum + SUM_W'($signed(prod[i*PROD_W +: PROD_W]));
      end
   end

endmodule

// File: rtl/bb_fusion_accumulator.sv
// Two-stage accumulator: beat sum register, then group accumulate.
// Finished group results are held until the consumer takes them.
module bb_fusion_accumulator
   import bitfusion_pkg::*;
#(
   parameter int NUM_BB = NUM_BB_D,
   parameter int PROD_W = PROD_W_D,
   parameter int ACC_W  = ACC_W_D,
   parameter int CNT_W  = CNT_W_D
) (
   input logic        clk,
   input logic        rst_n,
   bb_fusion_if.slave bus
);

   localparam int SUM_W = PROD_W + $clog2(NUM_BB);

   logic             adv;
   logic [SUM_W-1:0] tree_sum;

   logic             s1_v_q, s1_v_d;
   logic             s1_last_q, s1_last_d;
   logic [SUM_W-1:0] s1_sum_q, s1_sum_d;

   fsm_e             state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_acc_q, out_acc_d;
   logic [CNT_W-1:0] out_beats_q, out_beats_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0] acc_base, addend, nxt;
   logic [CNT_W-1:0] cnt_base, cnt_sat;
   logic             ovf_base, ovf_now;

   bb_adder_tree #(
      .NUM_BB (NUM_BB),
      .PROD_W (PROD_W),
      .SUM_W  (SUM_W)
   ) u_tree (
      .prod (bus.in_prod),
      .sum  (tree_sum)
   );

   // The whole pipeline freezes while a result waits on the consumer.
   assign adv          = ~(out_valid_q & ~bus.out_ready);
   assign bus.in_ready = adv;

   always_comb begin
      acc_base = (state_q == ACCUM) ? acc_q : '0;
      cnt_base = (state_q == ACCUM) ? cnt_q : '0;
      ovf_base = (state_q == ACCUM) ? ovf_q : 1'b0;
      addend   = ACC_W'(sext64(64'(s1_sum_q), SUM_W));
      nxt      = acc_base + addend;
      ovf_now  = (acc_base[ACC_W-1] == addend[ACC_W-1]) &&
                 (nxt[ACC_W-1] != acc_base[ACC_W-1]);
      cnt_sat  = (cnt_base == '1) ? cnt_base
                                  : cnt_base + CNT_W'(1);
   end

   always_comb begin
      s1_v_d      = s1_v_q;
      s1_last_d   = s1_last_q;
      s1_sum_d    = s1_sum_q;
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_acc_d   = out_acc_q;
      out_beats_d = out_beats_q;
      out_ovf_d   = out_ovf_q;
      if (adv) begin
         s1_v_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_sum_d  = tree_sum;
            s1_last_d = bus.in_last;
         end
         if (bus.out_ready) out_valid_d = 1'b0;
         if (s1_v_q) begin
            if (s1_last_q) begin
               out_valid_d = 1'b1;
               out_acc_d   = nxt;
               out_beats_d = cnt_sat;
               out_ovf_d   = ovf_base | ovf_now;
               acc_d       = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               state_d     = IDLE;
            end else begin
               acc_d   = nxt;
               cnt_d   = cnt_sat;
               ovf_d   = ovf_base | ovf_now;
               state_d = ACCUM;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q      <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_sum_q    <= '0;
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_beats_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         s1_v_q      <= s1_v_d;
         s1_last_q   <= s1_last_d;
         s1_sum_q    <= s1_sum_d;
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_acc_q   <= out_acc_d;
         out_beats_q <= out_beats_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_beats = out_beats_q;
   assign bus.out_ovf   = out_ovf_q;

endmodule
